char_feature_extract: RTL

Reduces one binarized character region of the incoming pixel stream to the 40-bit 5-column × 8-row feature vector consumed by the template-matching classifier `char_ln`. It sits directly upstream of `char_ln`: it takes the binarized pixel stream plus the character bounding box from the segmentation stage, and majority-votes each grid cell over the box. It emits `char` with a one-cycle `char_valid` strobe once the box has been fully scanned.

---
 rtl/char_feature_extract.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/char_feature_extract.sv
// char_feature_extract: majority-votes one binarized character bounding box
// into a 5-column x 8-row grid and emits the 40-bit feature vector.
// Pipeline: pixel inputs registered (stage 1), votes/indices updated (stage 2),
// result published from the DONE state one cycle later.
module char_feature_extract #(
  parameter int CNT_W   = 12,
  parameter int COORD_W = 12
) (
  input  logic               pixelclk,
  input  logic               reset_n,
  input  logic               vs,
  input  logic               de,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               bin,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  output logic [39:0]        char,
  output logic               char_valid,
  output logic               box_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // One extra bit so box widths and step accumulators never wrap.
  localparam int ACC_W = COORD_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-2){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic               vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic               de_q, de_d, bin_q, bin_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [ACC_W-1:0]   w_q, w_d, h_q, h_d;
  logic [ACC_W-1:0]   col_acc_q, col_acc_d, row_acc_q, row_acc_d;
  logic [2:0]         col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0]   cnt_q [40];
  logic [CNT_W-1:0]   cnt_d [40];
  logic [39:0]        char_q, char_d;
  logic               char_valid_q, char_valid_d, box_err_q, box_err_d;

  logic               vs_rise, box_bad, in_box, at_x_min, at_x_max, last_pix;
  logic               accum_en, emit;
  logic [ACC_W-1:0]   w_new, h_new, col_acc_sum, row_acc_sum;
  logic [2:0]         col_sel;
  logic [5:0]         cell_idx;

  // vs edge from the registered copy; box checks use the live box inputs,
  // which are only captured on that edge.
  assign vs_rise  = vs_q & ~vs_prev_q;
  assign w_new    = ACC_W'(x_max) - ACC_W'(x_min) + ACC_W'(1);
  assign h_new    = ACC_W'(y_max) - ACC_W'(y_min) + ACC_W'(1);
  assign box_bad  = (x_max < x_min) | (y_max < y_min) |
                    (w_new < ACC_W'(5)) | (h_new < ACC_W'(8));

  // Stage-2 pixel classification against the latched box.
  assign in_box   = de_q & (x_q >= x_min_q) & (x_q <= x_max_q) &
                    (y_q >= y_min_q) & (y_q <= y_max_q);
  assign at_x_min = (x_q == x_min_q);
  assign at_x_max = (x_q == x_max_q);
  assign last_pix = in_box & at_x_max & (y_q == y_max_q);

  // Column restarts at the left edge of every row; rows only advance at x_max.
  assign col_sel     = at_x_min ? 3'd0 : col_q;
  assign col_acc_sum = (at_x_min ? '0 : col_acc_q) + ACC_W'(5);
  assign row_acc_sum = row_acc_q + ACC_W'(8);
  assign cell_idx    = 6'(row_q) * 6'd5 + 6'(col_sel);

  // FSM state register.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: a vs edge wins over everything, including the final pixel.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    if (vs_rise) begin
      state_d = box_bad ? IDLE : ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last_pix) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: enable voting in ACCUM, publish the vector in DONE.
  always_comb begin
    accum_en = 1'b0;
    emit     = 1'b0;
    case (state_q)
      ACCUM:   accum_en = ~vs_rise;
      DONE:    emit     = 1'b1;
      default: ;
    endcase
  end

  // Stage 1: register the pixel stream and vs.
  always_comb begin
    vs_d      = vs;
    vs_prev_d = vs_q;
    de_d      = de;
    x_d       = x;
    y_d       = y;
    bin_d     = bin;
  end

  // Stage 2: box latch, vote counters, Bresenham row/col stepping, result.
  always_comb begin
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    w_d          = w_q;
    h_d          = h_q;
    col_d        = col_q;
    row_d        = row_q;
    col_acc_d    = col_acc_q;
    row_acc_d    = row_acc_q;
    cnt_d        = cnt_q;
    char_d       = char_q;
    char_valid_d = 1'b0;
    box_err_d    = 1'b0;

    if (vs_rise) begin
      x_min_d   = x_min;
      x_max_d   = x_max;
      y_min_d   = y_min;
      y_max_d   = y_max;
      w_d       = w_new;
      h_d       = h_new;
      col_d     = '0;
      row_d     = '0;
      col_acc_d = '0;
      row_acc_d = '0;
      for (int i = 0; i < 40; i++) cnt_d[i] = '0;
      box_err_d = box_bad;
    end else if (accum_en && in_box) begin
      if (bin_q) begin
        if (cnt_q[cell_idx] != CNT_MAX) cnt_d[cell_idx] = cnt_q[cell_idx] + 1'b1;
      end else begin
        if (cnt_q[cell_idx] != CNT_MIN) cnt_d[cell_idx] = cnt_q[cell_idx] - 1'b1;
      end

      if (col_acc_sum >= w_q) begin
        col_acc_d = col_acc_sum - w_q;
        col_d     = (col_sel == 3'd4) ? 3'd4 : col_sel + 3'd1;
      end else begin
        col_acc_d = col_acc_sum;
        col_d     = col_sel;
      end

      if (at_x_max) begin
        if (row_acc_sum >= h_q) begin
          row_acc_d = row_acc_sum - h_q;
          row_d     = (row_q == 3'd7) ? 3'd7 : row_q + 3'd1;
        end else begin
          row_acc_d = row_acc_sum;
        end
      end
    end

    // Strictly positive vote sets the bit; a tie resolves to 0.
    if (emit) begin
      for (int i = 0; i < 40; i++)
        char_d[39-i] = ~cnt_q[i][CNT_W-1] & (|cnt_q[i]);
      char_valid_d = 1'b1;
    end
  end

  // Pipeline, box and datapath registers.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      bin_q        <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      col_acc_q    <= '0;
      row_acc_q    <= '0;
      // NOTE: the vote array is reset explicitly; it is a register file with
      // a defined power-up value, not a RAM that may be left uninitialised.
      for (int i = 0; i < 40; i++) cnt_q[i] <= '0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
      box_err_q    <= 1'b0;
    end else begin
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
      de_q         <= de_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bin_q        <= bin_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      col_acc_q    <= col_acc_d;
      row_acc_q    <= row_acc_d;
      cnt_q        <= cnt_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      box_err_q    <= box_err_d;
    end
  end

  assign char       = char_q;
  assign char_valid = char_valid_q;
  assign box_err    = box_err_q;

endmodule
